// File: rtl/systolic_tile_scheduler_pkg.sv
// Shared types and phase-length helpers for the systolic tile scheduler.
package systolic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } phase_e;

  function automatic int tile_w(input int max_tiles);
    return $clog2(max_tiles + 1);
  endfunction

  function automatic int load_len(input int y);
    return y;
  endfunction

  function automatic int stream_len(input int x, input int y);
    return x + y - 1;
  endfunction

  function automatic int drain_len(input int y);
    return y;
  endfunction

  function automatic int tile_len(input int x, input int y);
    return load_len(y) + stream_len(x, y) + drain_len(y);
  endfunction

endpackage

// File: rtl/systolic_tile_scheduler_skew_mask_gen.sv
// Wavefront column-enable mask for the skewed STREAM phase; pure compare logic
// so the operand skew buffers can share the same decode.
module skew_mask_gen #(
  parameter int X  = 4,
  parameter int Y  = 3,
  parameter int CW = 3
) (
  input  logic [CW-1:0] c,
  input  logic          en,
  output logic [Y-1:0]  col_en
);

  always_comb begin
    col_en = '0;
    for (int j = 0; j < Y; j++) begin
      col_en[j] = en && (int'(c) >= j) && (int'(c) < j + X);
    end
  end

endmodule

// File: rtl/systolic_tile_scheduler.sv
// Job-level controller stepping the systolic array through LOAD/STREAM/DRAIN
// for every output tile of an m x n job, n-inner order.
//
// state  | meaning
// IDLE   | waiting for a job descriptor (or reporting a zero-tile job)
// LOAD   | weight load, Y cycles
// STREAM | skewed operand injection, X+Y-1 cycles
// DRAIN  | accumulator drain, Y cycles; last beat closes the tile
module systolic_tile_scheduler
  import systolic_sched_pkg::*;
#(
  parameter int X         = 4,
  parameter int Y         = 3,
  parameter int MAX_TILES = 16,
  parameter int TW        = tile_w(MAX_TILES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [TW-1:0] cfg_m_tiles,
  input  logic [TW-1:0] cfg_n_tiles,
  input  logic          stall,
  input  logic          abort,
  output logic [1:0]    phase,
  output logic          w_load,
  output logic [Y-1:0]  col_en,
  output logic          acc_drain,
  output logic [TW-1:0] tile_m,
  output logic [TW-1:0] tile_n,
  output logic          tile_done,
  output logic          job_done,
  output logic          busy
);

  localparam int LOAD_LEN   = load_len(Y);
  localparam int STREAM_LEN = stream_len(X, Y);
  localparam int DRAIN_LEN  = drain_len(Y);
  localparam int CW         = $clog2(STREAM_LEN);

  localparam logic [CW-1:0] C_LOAD_END   = CW'(LOAD_LEN - 1);
  localparam logic [CW-1:0] C_STREAM_END = CW'(STREAM_LEN - 1);
  localparam logic [CW-1:0] C_DRAIN_END  = CW'(DRAIN_LEN - 1);

  phase_e        state;
  logic [CW-1:0] c;
  logic [TW-1:0] m_tiles;
  logic [TW-1:0] n_tiles;
  logic          zero_pend;
  logic          last_col;
  logic          last_tile;
  logic          last_beat;

  assign last_col  = (tile_n == n_tiles - TW'(1));
  assign last_tile = last_col && (tile_m == m_tiles - TW'(1));
  assign last_beat = (state == DRAIN) && (c == C_DRAIN_END) && !stall && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      c         <= '0;
      tile_m    <= '0;
      tile_n    <= '0;
      m_tiles   <= '0;
      n_tiles   <= '0;
      zero_pend <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      c         <= '0;
      tile_m    <= '0;
      tile_n    <= '0;
      zero_pend <= 1'b0;
    end else if (state == IDLE) begin
      // A zero-tile job only owes its job_done pulse; hold it through a stall.
      if (zero_pend) begin
        if (!stall) zero_pend <= 1'b0;
      end else if (cfg_valid) begin
        m_tiles <= cfg_m_tiles;
        n_tiles <= cfg_n_tiles;
        if (cfg_m_tiles == '0 || cfg_n_tiles == '0) begin
          zero_pend <= 1'b1;
        end else begin
          state  <= LOAD;
          c      <= '0;
          tile_m <= '0;
          tile_n <= '0;
        end
      end
    end else if (!stall) begin
      case (state)
        LOAD: begin
          if (c == C_LOAD_END) begin
            state <= STREAM;
            c     <= '0;
          end else begin
            c <= c + CW'(1);
          end
        end
        STREAM: begin
          if (c == C_STREAM_END) begin
            state <= DRAIN;
            c     <= '0;
          end else begin
            c <= c + CW'(1);
          end
        end
        DRAIN: begin
          if (c == C_DRAIN_END) begin
            c <= '0;
            if (last_tile) begin
              state  <= IDLE;
              tile_m <= '0;
              tile_n <= '0;
            end else begin
              state <= LOAD;
              if (last_col) begin
                tile_n <= '0;
                tile_m <= tile_m + TW'(1);
              end else begin
                tile_n <= tile_n + TW'(1);
              end
            end
          end else begin
            c <= c + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  skew_mask_gen #(.X(X), .Y(Y), .CW(CW)) u_skew (
    .c      (c),
    .en     ((state == STREAM) && !stall),
    .col_en (col_en)
  );

  assign phase     = state;
  assign cfg_ready = (state == IDLE) && !zero_pend;
  assign busy      = (state != IDLE) || zero_pend;
  assign w_load    = (state == LOAD) && !stall;
  assign acc_drain = (state == DRAIN) && !stall;
  assign tile_done = last_beat;
  assign job_done  = (last_beat && last_tile) || (zero_pend && !stall && !abort);

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed bench for systolic_tile_scheduler at X=4, Y=3 (12-cycle tiles).
module tb_systolic_tile_scheduler;

  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [TW-1:0] cfg_m_tiles = '0;
  logic [TW-1:0] cfg_n_tiles = '0;
  logic          stall = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    phase;
  logic          w_load;
  logic [2:0]    col_en;
  logic          acc_drain;
  logic [TW-1:0] tile_m;
  logic [TW-1:0] tile_n;
  logic          tile_done;
  logic          job_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  systolic_tile_scheduler #(.X(4), .Y(3), .MAX_TILES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_m_tiles (cfg_m_tiles),
    .cfg_n_tiles (cfg_n_tiles),
    .stall       (stall),
    .abort       (abort),
    .phase       (phase),
    .w_load      (w_load),
    .col_en      (col_en),
    .acc_drain   (acc_drain),
    .tile_m      (tile_m),
    .tile_n      (tile_n),
    .tile_done   (tile_done),
    .job_done    (job_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Hand-derived per-tile schedule: p = cycle within tile, 0..11.
  function automatic int exp_phase(input int p);
    if (p < 3) return 1;
    if (p < 9) return 2;
    return 3;
  endfunction

  function automatic int exp_col(input int p);
    case (p)
      3: return 1;
      4: return 3;
      5: return 7;
      6: return 7;
      7: return 6;
      8: return 4;
      default: return 0;
    endcase
  endfunction

  // Called #1 after a posedge; returns #1 after the accepting posedge.
  task automatic start_job(input int m, input int n);
    cfg_m_tiles = TW'(m);
    cfg_n_tiles = TW'(n);
    cfg_valid   = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // 1x1 job, optionally stalled for two cycles starting at cycle stall_at.
  task automatic run_1x1(input int stall_at, input string tg);
    int dur;
    int nst;
    int p;
    logic st;
    dur = (stall_at != 0) ? 14 : 12;
    start_job(1, 1);
    for (int k = 1; k <= dur + 1; k++) begin
      st = (stall_at != 0) && (k == stall_at || k == stall_at + 1);
      stall = st;
      #1;
      if (k <= dur) begin
        nst = 0;
        if (stall_at != 0 && k > stall_at) nst = (k - stall_at > 2) ? 2 : k - stall_at;
        p = k - 1 - nst;
        chk({tg, "_phase"},   phase,     exp_phase(p));
        chk({tg, "_w_load"},  w_load,    st ? 0 : int'(p < 3));
        chk({tg, "_col_en"},  col_en,    st ? 0 : exp_col(p));
        chk({tg, "_drain"},   acc_drain, st ? 0 : int'(p >= 9));
        chk({tg, "_tdone"},   tile_done, int'(!st && p == 11));
        chk({tg, "_jdone"},   job_done,  int'(!st && p == 11));
      end else begin
        chk({tg, "_end_phase"}, phase, 0);
        chk({tg, "_end_ready"}, cfg_ready, 1);
        chk({tg, "_end_jdone"}, job_done, 0);
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
  endtask

  initial begin
    int idx;
    int p;
    int td_cnt;

    // reset state
    #12;
    chk("rst_phase", phase, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wload", w_load, 0);
    chk("rst_col", col_en, 0);
    chk("rst_drain", acc_drain, 0);
    chk("rst_tdone", tile_done, 0);
    chk("rst_jdone", job_done, 0);
    chk("rst_tm", tile_m, 0);
    chk("rst_tn", tile_n, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_1x1(0, "single");

    // 2x3 job, n-inner order, job_done at +72
    td_cnt = 0;
    start_job(2, 3);
    for (int k = 1; k <= 73; k++) begin
      #1;
      if (k <= 72) begin
        idx = (k - 1) / 12;
        p   = (k - 1) % 12;
        chk("m23_tm", tile_m, idx / 3);
        chk("m23_tn", tile_n, idx % 3);
        chk("m23_phase", phase, exp_phase(p));
        chk("m23_col", col_en, exp_col(p));
        chk("m23_tdone", tile_done, int'(p == 11));
        chk("m23_jdone", job_done, int'(k == 72));
        if (tile_done) td_cnt++;
      end else begin
        chk("m23_end_phase", phase, 0);
        chk("m23_end_ready", cfg_ready, 1);
        chk("m23_end_busy", busy, 0);
      end
      @(posedge clk); #1;
    end
    chk("m23_tile_count", td_cnt, 6);

    // zero-tile job
    start_job(0, 5);
    #1;
    chk("zero_jdone1", job_done, 1);
    chk("zero_busy1", busy, 1);
    chk("zero_ready1", cfg_ready, 0);
    chk("zero_phase1", phase, 0);
    chk("zero_wload1", w_load, 0);
    chk("zero_col1", col_en, 0);
    @(posedge clk); #2;
    chk("zero_jdone2", job_done, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_ready2", cfg_ready, 1);
    chk("zero_wload2", w_load, 0);
    chk("zero_col2", col_en, 0);
    @(posedge clk); #1;

    // two stalled cycles at STREAM c=2 (cycle 6)
    run_1x1(6, "stall");

    // abort on last DRAIN beat of tile (0,1) in a 2x2 job, stall also high
    start_job(2, 2);
    for (int k = 1; k <= 23; k++) begin
      #1;
      if (k == 13) chk("abt_tn", tile_n, 1);
      @(posedge clk); #1;
    end
    stall = 1'b1;
    abort = 1'b1;
    #1;
    chk("abt_phase_drain", phase, 3);
    chk("abt_tdone", tile_done, 0);
    chk("abt_jdone", job_done, 0);
    @(posedge clk); #1;
    stall = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("abt_post_phase", phase, 0);
      chk("abt_post_ready", cfg_ready, 1);
      chk("abt_post_busy", busy, 0);
      chk("abt_post_tdone", tile_done, 0);
      chk("abt_post_jdone", job_done, 0);
      @(posedge clk); #1;
    end

    // async reset mid-STREAM
    start_job(1, 1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    #1;
    chk("arst_pre_phase", phase, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_col", col_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_wload", w_load, 0);
    chk("arst_drain", acc_drain, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_1x1(0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
